// File: rtl/cg_tlb_setassociative.sv
// Set-associative TLB: ASID-tagged entries, per-set round-robin replacement, full/ASID flush.
// Optional macro CG_TLB_GLOBAL_EN adds a per-entry global bit (ASID-agnostic, survives ASID flush).
module cg_tlb_setassociative #(
  parameter int unsigned VADDR_WIDTH = 39,
  parameter int unsigned PADDR_WIDTH = 56,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned PAGE_OFFSET = 12,
  parameter int unsigned SETS        = 4,
  parameter int unsigned WAYS        = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_vaddr_valid,
  input  logic [VADDR_WIDTH-1:0] i_vaddr,
  input  logic [ASID_WIDTH-1:0]  i_asid,
  output logic                   o_paddr_valid,
  output logic [PADDR_WIDTH-1:0] o_paddr,
  output logic                   o_busy,
  output logic                   o_tlb_miss,
  output logic [VADDR_WIDTH-1:0] o_tlb_miss_vaddr,
  output logic [ASID_WIDTH-1:0]  o_tlb_miss_asid,
  input  logic                   i_ptw_valid,
  input  logic [PADDR_WIDTH-1:0] i_ptw_paddr,
`ifdef CG_TLB_GLOBAL_EN
  input  logic                   i_ptw_global,
`endif
  input  logic                   i_flush,
  input  logic                   i_flush_asid_valid,
  input  logic [ASID_WIDTH-1:0]  i_flush_asid
);

  localparam int unsigned LogSets = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int unsigned SetW    = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TagW    = VADDR_WIDTH - PAGE_OFFSET - LogSets;
  localparam int unsigned PpnW    = PADDR_WIDTH - PAGE_OFFSET;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e                 state_q, state_d;
  logic                   paddr_valid_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic [VADDR_WIDTH-1:0] miss_vaddr_q;
  logic [ASID_WIDTH-1:0]  miss_asid_q;

  logic [WAYS-1:0]        valid_q [SETS];
  logic [TagW-1:0]        tag_q   [SETS][WAYS];
  logic [ASID_WIDTH-1:0]  asid_q  [SETS][WAYS];
  logic [PpnW-1:0]        ppn_q   [SETS][WAYS];
  logic [WayW-1:0]        rr_q    [SETS];
`ifdef CG_TLB_GLOBAL_EN
  logic [WAYS-1:0]        global_q [SETS];
`endif

  logic [SetW-1:0] set_lu, miss_set;
  logic [TagW-1:0] tag_lu, miss_tag;
  logic            hit, asid_hit;
  logic [PpnW-1:0] hit_ppn;
  logic [WAYS-1:0] kill [SETS];
  logic [WAYS-1:0] post_valid;
  logic [WayW-1:0] victim, rr_inc;
  logic            found_free;
  logic            lookup_go, fill_we;
  logic            unused_ptw_offset;

  assign unused_ptw_offset = ^i_ptw_paddr[PAGE_OFFSET-1:0];

  assign set_lu   = SetW'(i_vaddr >> PAGE_OFFSET) & SetW'(SETS - 1);
  assign tag_lu   = TagW'(i_vaddr >> (PAGE_OFFSET + LogSets));
  assign miss_set = SetW'(miss_vaddr_q >> PAGE_OFFSET) & SetW'(SETS - 1);
  assign miss_tag = TagW'(miss_vaddr_q >> (PAGE_OFFSET + LogSets));

  assign lookup_go = (state_q == StIdle) && i_vaddr_valid && !i_flush;
  assign fill_we   = (state_q == StMiss) && i_ptw_valid && i_rstn;

  always_comb begin
    hit      = 1'b0;
    hit_ppn  = '0;
    asid_hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef CG_TLB_GLOBAL_EN
      asid_hit = global_q[set_lu][w] || (asid_q[set_lu][w] == i_asid);
`else
      asid_hit = (asid_q[set_lu][w] == i_asid);
`endif
      if (valid_q[set_lu][w] && (tag_q[set_lu][w] == tag_lu) && asid_hit) begin
        hit     = 1'b1;
        hit_ppn = ppn_q[set_lu][w];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      kill[s] = '0;
      for (int w = 0; w < WAYS; w++) begin
`ifdef CG_TLB_GLOBAL_EN
        kill[s][w] = i_flush && (!i_flush_asid_valid ||
                                 ((asid_q[s][w] == i_flush_asid) && !global_q[s][w]));
`else
        kill[s][w] = i_flush && (!i_flush_asid_valid || (asid_q[s][w] == i_flush_asid));
`endif
      end
    end
  end

  // Victim is picked against post-flush validity so a same-cycle flush frees ways first.
  always_comb begin
    post_valid = valid_q[miss_set] & ~kill[miss_set];
    victim     = rr_q[miss_set];
    found_free = ~&post_valid;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!post_valid[w]) victim = WayW'(w);
    end
    rr_inc = (rr_q[miss_set] == WayW'(WAYS - 1)) ? '0 : rr_q[miss_set] + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (lookup_go && !hit) state_d = StMiss;
      StMiss: if (i_ptw_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q       <= StIdle;
      paddr_valid_q <= 1'b0;
      paddr_q       <= '0;
      miss_vaddr_q  <= '0;
      miss_asid_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      paddr_valid_q <= 1'b0;
      if (lookup_go && hit) begin
        paddr_valid_q <= 1'b1;
        paddr_q       <= {hit_ppn, i_vaddr[PAGE_OFFSET-1:0]};
      end
      if (lookup_go && !hit) begin
        miss_vaddr_q <= i_vaddr;
        miss_asid_q  <= i_asid;
      end
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= valid_q[s] & ~kill[s];
      end
      if (fill_we) begin
        valid_q[miss_set][victim] <= 1'b1;
        if (!found_free) rr_q[miss_set] <= rr_inc;
        paddr_valid_q <= 1'b1;
        paddr_q       <= {i_ptw_paddr[PADDR_WIDTH-1:PAGE_OFFSET], miss_vaddr_q[PAGE_OFFSET-1:0]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_we) begin
      tag_q[miss_set][victim]  <= miss_tag;
      asid_q[miss_set][victim] <= miss_asid_q;
      ppn_q[miss_set][victim]  <= i_ptw_paddr[PADDR_WIDTH-1:PAGE_OFFSET];
`ifdef CG_TLB_GLOBAL_EN
      global_q[miss_set][victim] <= i_ptw_global;
`endif
    end
  end

  assign o_paddr_valid    = paddr_valid_q;
  assign o_paddr          = paddr_q;
  assign o_busy           = (state_q == StMiss);
  assign o_tlb_miss       = (state_q == StMiss);
  assign o_tlb_miss_vaddr = miss_vaddr_q;
  assign o_tlb_miss_asid  = miss_asid_q;

endmodule
